// File: rtl/ads_sample_ctrl.sv
// ads_sample_ctrl
//   Converts each rising edge of the divided sample-rate level (div625) into
//   one chip-select/serial-clock frame on an ADS7883-class serial ADC. The
//   selected data window of the frame is returned as a parallel sample with a
//   one-cycle valid strobe. Everything runs on clk; div625 is only sampled.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   div625       sample-rate tick level, asynchronous to clk
//   en           1 = accept new ticks, 0 = ignore them
//   clr_ovr      one-cycle pulse, clears overrun (a same-cycle tick wins)
//   adc_sdo      ADC serial data, captured as adc_sclk goes 0->1
//   adc_cs_n     ADC chip select, active low
//   adc_sclk     ADC serial clock, idles high
//   sample       last captured sample, first received data bit is the MSB
//   sample_valid one-cycle strobe when sample updates
//   overrun      sticky, a qualifying tick arrived while a frame was running
//   frame_cnt    completed frames, wraps 0xFFFF -> 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cs_n=1, sclk=1, waiting for a qualifying tick
// SETUP   | cs_n=0, sclk=1 for SCLK_DIV cycles before the first bit
// SHIFT   | FRAME_BITS sclk periods, SCLK_DIV low then SCLK_DIV high
// DONE    | cs_n=1, sample/valid/frame_cnt updated, one cycle
// QUIET   | cs_n=1 for QUIET cycles before the next frame may start

module ads_sample_ctrl #(
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 2,
  parameter int DATA_BITS  = 12,
  parameter int SCLK_DIV   = 4,
  parameter int QUIET      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 div625,
  input  logic                 en,
  input  logic                 clr_ovr,
  input  logic                 adc_sdo,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 overrun,
  output logic [15:0]          frame_cnt
);

  localparam int TMR_MAX = (SCLK_DIV > QUIET) ? SCLK_DIV : QUIET;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  localparam logic [TMR_W-1:0] HALF_LOAD  = TMR_W'(SCLK_DIV - 1);
  localparam logic [TMR_W-1:0] QUIET_LOAD = TMR_W'(QUIET - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST  = BIT_W'(FRAME_BITS - 1);
  // Bit indices (first received bit = FRAME_BITS-1) that belong to the sample.
  localparam logic [BIT_W-1:0] DATA_HI    = BIT_W'(FRAME_BITS - 1 - LEAD_BITS);
  localparam logic [BIT_W-1:0] DATA_LO    = BIT_W'(FRAME_BITS - LEAD_BITS - DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_QUIET
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 sync2;
  logic                 prev;
  logic                 tick;
  logic                 in_window;
  logic [TMR_W-1:0]     tmr;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  assign tick      = sync2 & ~prev;
  assign in_window = (bit_cnt <= DATA_HI) && (bit_cnt >= DATA_LO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      tmr          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      sync1        <= div625;
      sync2        <= sync1;
      prev         <= sync2;
      sample_valid <= 1'b0;

      // Set wins over clear when both happen in the same cycle.
      if (tick && en && (state != S_IDLE))
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tick && en) begin
            state    <= S_SETUP;
            adc_cs_n <= 1'b0;
            tmr      <= HALF_LOAD;
          end
        end

        S_SETUP: begin
          if (tmr == '0) begin
            state    <= S_SHIFT;
            adc_sclk <= 1'b0;
            tmr      <= HALF_LOAD;
            bit_cnt  <= BIT_FIRST;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        // adc_sclk doubles as the half-period phase flag.
        S_SHIFT: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (!adc_sclk) begin
            adc_sclk <= 1'b1;
            tmr      <= HALF_LOAD;
            if (in_window)
              shreg <= {shreg[DATA_BITS-2:0], adc_sdo};
          end else if (bit_cnt == '0) begin
            state        <= S_DONE;
            adc_cs_n     <= 1'b1;
            sample       <= shreg;
            sample_valid <= 1'b1;
            frame_cnt    <= frame_cnt + 16'd1;
          end else begin
            adc_sclk <= 1'b0;
            tmr      <= HALF_LOAD;
            bit_cnt  <= bit_cnt - 1'b1;
          end
        end

        S_DONE: begin
          state <= S_QUIET;
          tmr   <= QUIET_LOAD;
        end

        S_QUIET: begin
          if (tmr == '0)
            state <= S_IDLE;
          else
            tmr <= tmr - 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
